i2f_sched: RTL and testbench

//  Shares one combinational i2f converter (d[31:0] -> a[31:0], p_lost) between two

---
 rtl/i2f_pkg.sv | 10 +
 rtl/i2f.sv | 44 ++++
 rtl/i2f_sched_rr_arb2.sv | 23 ++
 rtl/i2f_sched.sv | 115 +++++++++++
 tb/tb_i2f_sched.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2f_pkg.sv
// Shared definitions for the i2f scheduler: FSM state encoding and requester ID width.
package i2f_pkg;
  localparam int REQ_W = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/i2f.sv
// Combinational 32-bit two's-complement integer to IEEE-754 single conversion,
// round-to-nearest-even; p_lost flags any discarded non-zero bits.
module i2f (
  input  logic [31:0] d,
  output logic [31:0] a,
  output logic        p_lost
);
  function automatic logic [4:0] msb_pos(input logic [31:0] v);
    msb_pos = '0;
    for (int i = 0; i < 32; i++)
      if (v[i]) msb_pos = 5'(i);
  endfunction

  // norm holds the magnitude below the hidden bit: [30:8] mantissa, [7] guard, [6:0] sticky.
  function automatic logic [31:0] round_rne(input logic sign, input logic [7:0] exp,
                                            input logic [30:0] norm);
    logic [23:0] m;
    logic        up;
    up = norm[7] & ((|norm[6:0]) | norm[8]);
    m  = {1'b0, norm[30:8]} + 24'(up);
    if (m[23]) round_rne = {sign, exp + 8'd1, 23'd0};
    else       round_rne = {sign, exp, m[22:0]};
  endfunction

  logic signed [31:0] sd;
  logic               sign;
  logic        [31:0] mag;
  logic        [31:0] norm;
  logic        [4:0]  pos;

  always_comb begin
    sd     = d;
    sign   = sd[31];
    mag    = sign ? $unsigned(-sd) : $unsigned(sd);
    pos    = msb_pos(mag);
    norm   = mag << (5'd31 - pos);
    a      = '0;
    p_lost = 1'b0;
    if (mag != '0) begin
      a      = round_rne(sign, 8'd127 + {3'b000, pos}, norm[30:0]);
      p_lost = |norm[7:0];
    end
  end
endmodule

// File: rtl/i2f_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie and
// moves to the loser's side only when a grant is actually taken (adv).
module rr_arb2 #(
  parameter int PRIO_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       adv,
  output logic [1:0] gnt
);
  logic ptr;

  always_comb begin
    gnt = valid;
    if (&valid) gnt = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= 1'(PRIO_INIT);
    else if (adv) ptr <= gnt[0];
  end
endmodule

// File: rtl/i2f_sched.sv
// Shares one combinational i2f between two requesters: IDLE accepts, CONV gives the
// converter a full cycle between operand and result registers, DONE holds the result.
module i2f_sched
  import i2f_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int PRIO_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_d,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_d,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_a,
  output logic             res_p_lost,
  output logic             res_id,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] conv_cnt,
  output logic [CNT_W-1:0] lost_cnt
);
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state;
  logic [1:0]       gnt;
  logic             idle;
  logic             accept;
  logic [31:0]      d_sel;
  logic [31:0]      op_reg;
  logic [REQ_W-1:0] id_reg;
  logic [31:0]      cv_a;
  logic             cv_lost;

  assign idle       = (state == S_IDLE);
  assign accept     = idle & (|gnt);
  assign req0_ready = idle & gnt[0] & ~rst;
  assign req1_ready = idle & gnt[1] & ~rst;
  assign d_sel      = gnt[1] ? req1_d : req0_d;

  rr_arb2 #(.PRIO_INIT(PRIO_INIT)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({req1_valid, req0_valid}),
    .adv   (accept),
    .gnt   (gnt)
  );

  i2f u_i2f (
    .d      (op_reg),
    .a      (cv_a),
    .p_lost (cv_lost)
  );

  // Operand stage: only loaded on accept, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) op_reg <= d_sel;
  end

  // Control and result stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      id_reg     <= '0;
      res_valid  <= 1'b0;
      res_a      <= '0;
      res_p_lost <= 1'b0;
      res_id     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            id_reg <= gnt[1];
            state  <= S_CONV;
          end
        end
        S_CONV: begin
          res_a      <= cv_a;
          res_p_lost <= cv_lost;
          res_id     <= id_reg;
          res_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_cnt <= '0;
      lost_cnt <= '0;
    end else if (stat_clr) begin
      conv_cnt <= '0;
      lost_cnt <= '0;
    end else if (res_valid & res_ready) begin
      conv_cnt <= sat_inc(conv_cnt);
      if (res_p_lost) lost_cnt <= sat_inc(lost_cnt);
    end
  end
endmodule

// File: tb/tb_i2f_sched.sv
// Directed bench for i2f_sched: conversion table, arbitration order, DONE hold,
// mid-transaction reset, counter saturation (2-bit copy) and clear priority.
module tb_i2f_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, res_ready, stat_clr;
  logic [31:0] req0_d, req1_d;
  logic        req0_ready, req1_ready, res_valid, res_p_lost, res_id;
  logic [31:0] res_a;
  logic [15:0] conv_cnt, lost_cnt;
  logic        r0_ready_b, r1_ready_b, res_valid_b, res_p_lost_b, res_id_b;
  logic [31:0] res_a_b;
  logic [1:0]  conv_cnt_b, lost_cnt_b;

  int checks = 0;
  int errors = 0;
  int exp_c = 0, exp_l = 0, exp_c2 = 0, exp_l2 = 0;

  always #5 clk = ~clk;

  i2f_sched #(.CNT_W(16), .PRIO_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_d(req0_d), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_d(req1_d), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_a(res_a),
    .res_p_lost(res_p_lost), .res_id(res_id), .stat_clr(stat_clr),
    .conv_cnt(conv_cnt), .lost_cnt(lost_cnt)
  );

  i2f_sched #(.CNT_W(2), .PRIO_INIT(0)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_d(req0_d), .req0_ready(r0_ready_b),
    .req1_valid(req1_valid), .req1_d(req1_d), .req1_ready(r1_ready_b),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_a(res_a_b),
    .res_p_lost(res_p_lost_b), .res_id(res_id_b), .stat_clr(stat_clr),
    .conv_cnt(conv_cnt_b), .lost_cnt(lost_cnt_b)
  );

  typedef struct {
    logic        id;
    logic [31:0] d;
    logic [31:0] a;
    logic        lost;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_hs(input logic lost);
    if (exp_c < 65535) exp_c++;
    if (exp_c2 < 3) exp_c2++;
    if (lost) begin
      if (exp_l < 65535) exp_l++;
      if (exp_l2 < 3) exp_l2++;
    end
  endtask

  task automatic model_clr();
    exp_c = 0; exp_l = 0; exp_c2 = 0; exp_l2 = 0;
  endtask

  task automatic chk_cnts(input string tag);
    chk($sformatf("%s conv_cnt", tag), conv_cnt, exp_c);
    chk($sformatf("%s lost_cnt", tag), lost_cnt, exp_l);
    chk($sformatf("%s conv_cnt2", tag), conv_cnt_b, exp_c2);
    chk($sformatf("%s lost_cnt2", tag), lost_cnt_b, exp_l2);
  endtask

  // Single requester from IDLE: accept, CONV, DONE check, handshake.
  task automatic do_conv(input logic id, input logic [31:0] d, input logic [31:0] ea,
                         input logic el, input string tag);
    if (id) begin req1_valid = 1'b1; req1_d = d; end
    else    begin req0_valid = 1'b1; req0_d = d; end
    #1;
    chk($sformatf("%s ready", tag), id ? req1_ready : req0_ready, 1);
    chk($sformatf("%s other_ready", tag), id ? req0_ready : req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk($sformatf("%s conv_valid", tag), res_valid, 0);
    tick();
    chk($sformatf("%s res_valid", tag), res_valid, 1);
    chk($sformatf("%s res_a", tag), res_a, ea);
    chk($sformatf("%s p_lost", tag), res_p_lost, el);
    chk($sformatf("%s res_id", tag), res_id, id);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    model_hs(el);
    chk($sformatf("%s post_valid", tag), res_valid, 0);
    chk_cnts(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ids;
    int         got;

    vt[0] = '{1'b0, 32'h00000001, 32'h3F800000, 1'b0};
    vt[1] = '{1'b1, 32'hFFFFFFFF, 32'hBF800000, 1'b0};
    vt[2] = '{1'b1, 32'h00000000, 32'h00000000, 1'b0};
    vt[3] = '{1'b0, 32'h01000001, 32'h4B800000, 1'b1};
    vt[4] = '{1'b0, 32'h80000000, 32'hCF000000, 1'b0};
    vt[5] = '{1'b1, 32'h7FFFFFFF, 32'h4F000000, 1'b1};
    vt[6] = '{1'b0, 32'h00FFFFFF, 32'h4B7FFFFF, 1'b0};
    vt[7] = '{1'b1, 32'h01000003, 32'h4B800002, 1'b1};
    vt[8] = '{1'b0, 32'h00000003, 32'h40400000, 1'b0};
    vt[9] = '{1'b1, 32'hFFFFFFFE, 32'hC0000000, 1'b0};

    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0; stat_clr = 1'b0;
    req0_d = '0; req1_d = '0;
    tick(); tick();
    chk("rst res_valid", res_valid, 0);
    chk("rst res_a", res_a, 0);
    chk("rst res_p_lost", res_p_lost, 0);
    chk("rst res_id", res_id, 0);
    chk("rst ready0", req0_ready, 0);
    chk("rst ready1", req1_ready, 0);
    chk_cnts("rst");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++)
      do_conv(vt[i].id, vt[i].d, vt[i].a, vt[i].lost, $sformatf("vec%0d", i));

    // Alternating grants under contention, starting from PRIO_INIT=0.
    rst = 1'b1; tick(); rst = 1'b0; model_clr(); tick();
    req0_d = 32'h00000001; req1_d = 32'h00000002;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    ids = 'x; got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      tick();
      if (res_valid) begin
        ids[got] = res_id;
        got++;
        model_hs(1'b0);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    res_ready = 1'b0;
    chk("rr ids", ids, 4'b1010);
    chk_cnts("rr");

    do_conv(1'b1, 32'h00000002, 32'h40000000, 1'b0, "solo1a");
    do_conv(1'b1, 32'h00000002, 32'h40000000, 1'b0, "solo1b");
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    chk("ptr kept ready0", req0_ready, 1);
    chk("ptr kept ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("ptr kept id", res_id, 0);
    chk("ptr kept a", res_a, 32'h3F800000);
    res_ready = 1'b1; tick(); res_ready = 1'b0; model_hs(1'b0);

    // DONE hold with backpressure and both requesters pending.
    req0_valid = 1'b1; req0_d = 32'h00000003; tick();
    req1_valid = 1'b1; req1_d = 32'h00000005;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold%0d valid", c), res_valid, 1);
      chk($sformatf("hold%0d a", c), res_a, 32'h40400000);
      chk($sformatf("hold%0d id", c), res_id, 0);
      chk($sformatf("hold%0d rdy", c), {req0_ready, req1_ready}, 2'b00);
      chk($sformatf("hold%0d cnt", c), conv_cnt, exp_c);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1; tick(); res_ready = 1'b0; model_hs(1'b0);
    chk_cnts("hold end");

    // Reset while in CONV aborts the transaction.
    req0_valid = 1'b1; req0_d = 32'h01000001; tick();
    req0_valid = 1'b0;
    rst = 1'b1; #1;
    model_clr();
    chk("abort res_valid", res_valid, 0);
    chk("abort res_a", res_a, 0);
    chk("abort res_p_lost", res_p_lost, 0);
    chk("abort res_id", res_id, 0);
    chk("abort ready", {req0_ready, req1_ready}, 2'b00);
    chk_cnts("abort");
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("abort quiet%0d", c), res_valid, 0);
    end

    // Saturation of the 2-bit counters.
    for (int k = 0; k < 5; k++)
      do_conv(1'b0, 32'h01000001, 32'h4B800000, 1'b1, $sformatf("sat%0d", k));
    chk("sat conv_cnt2", conv_cnt_b, 2'd3);
    chk("sat lost_cnt2", lost_cnt_b, 2'd3);
    chk("sat conv_cnt16", conv_cnt, 16'd5);

    // Clear wins over a same-cycle handshake.
    req1_valid = 1'b1; req1_d = 32'h01000001; tick();
    req1_valid = 1'b0; tick();
    chk("clr res_valid", res_valid, 1);
    res_ready = 1'b1; stat_clr = 1'b1; tick();
    res_ready = 1'b0; stat_clr = 1'b0;
    model_clr();
    chk_cnts("clr");
    chk("clr post_valid", res_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
